// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Multiplexed seven-segment display driver for NUM_DIGITS hex digits sharing
// one segment bus, with one anode line per digit. The digits are scanned one
// slot at a time. Each slot starts with a blank window so that segment data
// for one digit never bleeds onto its neighbour's anode. New values are
// captured into a pending register and moved to the displayed (shadow) copy
// only at a frame boundary, so a single frame never mixes old and new digits.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   value        hex nibbles, nibble i = value[4i+3:4i], digit 0 rightmost
//   dp_in        decimal point request per digit
//   digit_en     per-digit enable (0 blanks that digit)
//   lz_suppress  leading-zero suppression enable, captured with load
//   load         capture strobe for value/dp_in/digit_en/lz_suppress
//   seg          segments, seg[0]=a .. seg[6]=g
//   dp           decimal point
//   an           anode select, an[i] drives digit i
//   digit_idx    digit whose slot the outputs are currently presenting
//   frame_done   one-cycle pulse when the outputs present digit 0, count 0
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int ACTIVE_LOW   = 1,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam bit INV   = (ACTIVE_LOW == 0);

    // Off levels for the pins in the selected polarity.
    localparam logic [6:0]            SEG_OFF = INV ? 7'h00 : 7'h7F;
    localparam logic                  DP_OFF  = INV ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = INV ? '0 : '1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    slotWrap, frameWrap;

    logic [4*NUM_DIGITS-1:0] pendValue_q, shValue_q;
    logic [NUM_DIGITS-1:0]   pendDp_q, shDp_q;
    logic [NUM_DIGITS-1:0]   pendEn_q, shEn_q;
    logic                    pendLz_q, shLz_q;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [IDX_W-1:0]        digitIdx_q;
    logic                    frameDone_q, frameDone_d;

    logic [NUM_DIGITS:0]     zeroFrom;
    logic [3:0]              curNib;
    logic                    curEn, curDp, curZero;
    logic                    suppressed, visible;
    logic [6:0]              segAl;
    logic [NUM_DIGITS-1:0]   anAl;

    // Active-low hex decode, a..g in bits 0..6.
    function automatic logic [6:0] hexDecode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot prescaler and digit index; the index advances once per slot.
    always_comb begin
        slotWrap  = (cnt_q == CNT_W'(SCAN_DIV - 1));
        frameWrap = slotWrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d     = slotWrap ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slotWrap) begin
            idx_d = frameWrap ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Pending copy follows every load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendValue_q <= '0;
            pendDp_q    <= '0;
            pendEn_q    <= '0;
            pendLz_q    <= 1'b0;
        end else if (load) begin
            pendValue_q <= value;
            pendDp_q    <= dp_in;
            pendEn_q    <= digit_en;
            pendLz_q    <= lz_suppress;
        end
    end

    // Shadow copy only changes at a frame boundary. A load landing on the
    // boundary cycle bypasses the pending register so it is not lost for a
    // whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shValue_q <= '0;
            shDp_q    <= '0;
            shEn_q    <= '0;
            shLz_q    <= 1'b0;
        end else if (frameWrap) begin
            if (load) begin
                shValue_q <= value;
                shDp_q    <= dp_in;
                shEn_q    <= digit_en;
                shLz_q    <= lz_suppress;
            end else begin
                shValue_q <= pendValue_q;
                shDp_q    <= pendDp_q;
                shEn_q    <= pendEn_q;
                shLz_q    <= pendLz_q;
            end
        end
    end

    // zeroFrom[i] is set when nibbles i..NUM_DIGITS-1 of the shadow are all
    // zero, which is exactly the leading-zero condition for digit i.
    always_comb begin
        zeroFrom             = '0;
        zeroFrom[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroFrom[i] = (shValue_q[4*i +: 4] == 4'h0) && zeroFrom[i+1];
        end
    end

    // Select the current digit's data and build the next pin values in
    // active-low form, then apply the output polarity.
    always_comb begin
        curNib  = 4'h0;
        curEn   = 1'b0;
        curDp   = 1'b0;
        curZero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                curNib  = shValue_q[4*i +: 4];
                curEn   = shEn_q[i];
                curDp   = shDp_q[i];
                curZero = zeroFrom[i];
            end
        end

        suppressed = shLz_q && (idx_q != '0) && curZero;
        visible    = curEn && !suppressed && (cnt_q >= CNT_W'(BLANK_CYCLES));

        segAl = visible ? hexDecode(curNib) : 7'h7F;
        anAl  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (visible && (idx_q == IDX_W'(i))) begin
                anAl[i] = 1'b0;
            end
        end

        seg_d       = INV ? ~segAl : segAl;
        dp_d        = INV ? (visible && curDp) : !(visible && curDp);
        an_d        = INV ? ~anAl : anAl;
        frameDone_d = (cnt_q == '0) && (idx_q == '0);
    end

    // Output registers; reset forces the off level asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            an_q        <= AN_OFF;
            digitIdx_q  <= '0;
            frameDone_q <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            digitIdx_q  <= idx_q;
            frameDone_q <= frameDone_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_idx  = digitIdx_q;
    assign frame_done = frameDone_q;

endmodule
